// File: rtl/spi_ram_arbiter_if.sv
// ---------------------------------------------------------------------------
// spi_ram_arbiter_if
// Bundles every non-clock/reset signal of spi_ram_arbiter.
//   SPI side : spi_rx_valid/spi_rx_data in, spi_tx_valid/spi_tx_data out,
//              spi_overrun sticky error out.
//   Host side: host_req/host_we/host_addr/host_wdata in,
//              host_gnt/host_rvalid/host_rdata out.
//   RAM side : ram_en/ram_we/ram_addr/ram_wdata out, ram_rdata in.
// Modports: slave  = the arbiter itself,
//           master = the environment (SPI slave, host, RAM).
// ---------------------------------------------------------------------------
interface spi_ram_arbiter_if #(
  parameter int ADDR_SIZE = 8,
  parameter int DATA_W    = 8
);
  logic                 spi_rx_valid;
  logic [DATA_W+1:0]    spi_rx_data;
  logic                 spi_tx_valid;
  logic [DATA_W-1:0]    spi_tx_data;
  logic                 host_req;
  logic                 host_we;
  logic [ADDR_SIZE-1:0] host_addr;
  logic [DATA_W-1:0]    host_wdata;
  logic                 host_gnt;
  logic                 host_rvalid;
  logic [DATA_W-1:0]    host_rdata;
  logic                 ram_en;
  logic                 ram_we;
  logic [ADDR_SIZE-1:0] ram_addr;
  logic [DATA_W-1:0]    ram_wdata;
  logic [DATA_W-1:0]    ram_rdata;
  logic                 spi_overrun;

  modport slave (
    input  spi_rx_valid, spi_rx_data, host_req, host_we, host_addr,
           host_wdata, ram_rdata,
    output spi_tx_valid, spi_tx_data, host_gnt, host_rvalid, host_rdata,
           ram_en, ram_we, ram_addr, ram_wdata, spi_overrun
  );

  modport master (
    output spi_rx_valid, spi_rx_data, host_req, host_we, host_addr,
           host_wdata, ram_rdata,
    input  spi_tx_valid, spi_tx_data, host_gnt, host_rvalid, host_rdata,
           ram_en, ram_we, ram_addr, ram_wdata, spi_overrun
  );
endinterface

// File: rtl/spi_ram_arbiter.sv
// ---------------------------------------------------------------------------
// spi_ram_arbiter
// Shares one single-port RAM between an SPI command channel and a host port.
// SPI words are [DATA_W+1:DATA_W] command, [DATA_W-1:0] payload:
//   00 load write address, 10 load read address,
//   01 queue write of payload, 11 queue read.
// One RAM access per cycle, round-robin between SPI and host. Read data
// comes back two cycles after the strobe to whichever side issued it.
// Ports: clk, rst (async, active-high), bus (spi_ram_arbiter_if.slave).
// ---------------------------------------------------------------------------
module spi_ram_arbiter #(
  parameter int ADDR_SIZE = 8,
  parameter int DATA_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  spi_ram_arbiter_if.slave bus
);
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_PEND   = 2'd1;
  localparam logic [1:0] ST_RDWAIT = 2'd2;

  localparam logic [1:0] CMD_WADDR = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_RADDR = 2'b10;

  logic                 rx_prev_q, rx_prev_d;
  logic [1:0]           state_q, state_d;
  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
  logic                 pend_we_q, pend_we_d;
  logic [ADDR_SIZE-1:0] pend_addr_q, pend_addr_d;
  logic [DATA_W-1:0]    pend_wdata_q, pend_wdata_d;
  logic                 prefer_host_q, prefer_host_d;
  logic                 ram_en_q, ram_en_d;
  logic                 ram_we_q, ram_we_d;
  logic [ADDR_SIZE-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]    ram_wdata_q, ram_wdata_d;
  logic                 host_gnt_q, host_gnt_d;
  logic                 tag1_valid_q, tag1_valid_d;
  logic                 tag1_spi_q, tag1_spi_d;
  logic                 tag2_valid_q, tag2_valid_d;
  logic                 tag2_spi_q, tag2_spi_d;
  logic                 host_rvalid_q, host_rvalid_d;
  logic [DATA_W-1:0]    host_rdata_q, host_rdata_d;
  logic                 spi_tx_valid_q, spi_tx_valid_d;
  logic [DATA_W-1:0]    spi_tx_data_q, spi_tx_data_d;
  logic                 overrun_q, overrun_d;

  logic                 capture;
  logic [1:0]           cmd;
  logic [DATA_W-1:0]    payload;
  logic [ADDR_SIZE-1:0] payload_addr;
  logic                 spi_elig, host_elig, grant_spi, grant_host;

  assign capture      = bus.spi_rx_valid & ~rx_prev_q;
  assign cmd          = bus.spi_rx_data[DATA_W+1:DATA_W];
  assign payload      = bus.spi_rx_data[DATA_W-1:0];
  assign payload_addr = ADDR_SIZE'(payload);

  // A host granted last cycle is still holding host_req; ignore it for one
  // cycle so the same request is not granted twice.
  assign spi_elig   = (state_q == ST_PEND);
  assign host_elig  = bus.host_req & ~host_gnt_q;
  assign grant_spi  = spi_elig & (~host_elig | ~prefer_host_q);
  assign grant_host = host_elig & ~grant_spi;

  always_comb begin
    rx_prev_d      = bus.spi_rx_valid;
    state_d        = state_q;
    wr_addr_d      = wr_addr_q;
    rd_addr_d      = rd_addr_q;
    pend_we_d      = pend_we_q;
    pend_addr_d    = pend_addr_q;
    pend_wdata_d   = pend_wdata_q;
    prefer_host_d  = prefer_host_q;
    ram_en_d       = grant_spi | grant_host;
    ram_we_d       = 1'b0;
    ram_addr_d     = ram_addr_q;
    ram_wdata_d    = ram_wdata_q;
    host_gnt_d     = grant_host;
    tag1_valid_d   = (grant_spi & ~pend_we_q) | (grant_host & ~bus.host_we);
    tag1_spi_d     = grant_spi;
    tag2_valid_d   = tag1_valid_q;
    tag2_spi_d     = tag1_spi_q;
    host_rvalid_d  = 1'b0;
    host_rdata_d   = host_rdata_q;
    spi_tx_valid_d = spi_tx_valid_q;
    spi_tx_data_d  = spi_tx_data_q;
    overrun_d      = overrun_q;

    if (grant_spi) begin
      ram_we_d      = pend_we_q;
      ram_addr_d    = pend_addr_q;
      ram_wdata_d   = pend_wdata_q;
      prefer_host_d = 1'b1;
      state_d       = pend_we_q ? ST_IDLE : ST_RDWAIT;
    end else if (grant_host) begin
      ram_we_d      = bus.host_we;
      ram_addr_d    = bus.host_addr;
      ram_wdata_d   = bus.host_wdata;
      prefer_host_d = 1'b0;
    end

    if (capture) begin
      spi_tx_valid_d = 1'b0;
    end

    // ram_rdata is valid now, one cycle after the strobe seen by tag1.
    if (tag2_valid_q) begin
      if (tag2_spi_q) begin
        spi_tx_data_d  = bus.ram_rdata;
        spi_tx_valid_d = 1'b1;
        state_d        = ST_IDLE;
      end else begin
        host_rdata_d   = bus.ram_rdata;
        host_rvalid_d  = 1'b1;
      end
    end

    if (capture) begin
      if (cmd == CMD_WADDR) begin
        wr_addr_d = payload_addr;
      end else if (cmd == CMD_RADDR) begin
        rd_addr_d = payload_addr;
      end else if ((state_q == ST_IDLE) || (grant_spi && pend_we_q)) begin
        // A write leaving PEND on this edge frees the slot for the new entry.
        state_d      = ST_PEND;
        pend_we_d    = (cmd == CMD_WRITE);
        pend_addr_d  = (cmd == CMD_WRITE) ? wr_addr_q : rd_addr_q;
        pend_wdata_d = payload;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_prev_q      <= 1'b0;
      state_q        <= ST_IDLE;
      wr_addr_q      <= '0;
      rd_addr_q      <= '0;
      pend_we_q      <= 1'b0;
      pend_addr_q    <= '0;
      pend_wdata_q   <= '0;
      prefer_host_q  <= 1'b0;
      ram_en_q       <= 1'b0;
      ram_we_q       <= 1'b0;
      ram_addr_q     <= '0;
      ram_wdata_q    <= '0;
      host_gnt_q     <= 1'b0;
      tag1_valid_q   <= 1'b0;
      tag1_spi_q     <= 1'b0;
      tag2_valid_q   <= 1'b0;
      tag2_spi_q     <= 1'b0;
      host_rvalid_q  <= 1'b0;
      host_rdata_q   <= '0;
      spi_tx_valid_q <= 1'b0;
      spi_tx_data_q  <= '0;
      overrun_q      <= 1'b0;
    end else begin
      rx_prev_q      <= rx_prev_d;
      state_q        <= state_d;
      wr_addr_q      <= wr_addr_d;
      rd_addr_q      <= rd_addr_d;
      pend_we_q      <= pend_we_d;
      pend_addr_q    <= pend_addr_d;
      pend_wdata_q   <= pend_wdata_d;
      prefer_host_q  <= prefer_host_d;
      ram_en_q       <= ram_en_d;
      ram_we_q       <= ram_we_d;
      ram_addr_q     <= ram_addr_d;
      ram_wdata_q    <= ram_wdata_d;
      host_gnt_q     <= host_gnt_d;
      tag1_valid_q   <= tag1_valid_d;
      tag1_spi_q     <= tag1_spi_d;
      tag2_valid_q   <= tag2_valid_d;
      tag2_spi_q     <= tag2_spi_d;
      host_rvalid_q  <= host_rvalid_d;
      host_rdata_q   <= host_rdata_d;
      spi_tx_valid_q <= spi_tx_valid_d;
      spi_tx_data_q  <= spi_tx_data_d;
      overrun_q      <= overrun_d;
    end
  end

  assign bus.spi_tx_valid = spi_tx_valid_q;
  assign bus.spi_tx_data  = spi_tx_data_q;
  assign bus.host_gnt     = host_gnt_q;
  assign bus.host_rvalid  = host_rvalid_q;
  assign bus.host_rdata   = host_rdata_q;
  assign bus.ram_en       = ram_en_q;
  assign bus.ram_we       = ram_we_q;
  assign bus.ram_addr     = ram_addr_q;
  assign bus.ram_wdata    = ram_wdata_q;
  assign bus.spi_overrun  = overrun_q;
endmodule
